// File: rtl/mains_timer_sched_if.sv
// ---------------------------------------------------------------------------
// mains_timer_sched_if
//
// Bundle of the request/response signals between the requesters and the
// shared mains-derived countdown timer.
//
//   req       requester -> scheduler  level request per channel
//   dur_sec   requester -> scheduler  per-channel duration, channel i at
//                                     bits [i*SEC_W +: SEC_W]
//   grant     scheduler -> requester  one-hot owner of the timer
//   busy      scheduler -> requester  timer loaded / running / completing
//   done      scheduler -> requester  one-cycle pulse on owner's bit
//   abort     scheduler -> requester  one-cycle pulse on early withdrawal
//   sec_left  scheduler -> requester  remaining whole seconds, 0 when idle
//
// Modports: master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface mains_timer_sched_if #(
    parameter int CHANNELS = 4,
    parameter int SEC_W    = 10
);
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*SEC_W-1:0] dur_sec;
    logic [CHANNELS-1:0]       grant;
    logic                      busy;
    logic [CHANNELS-1:0]       done;
    logic                      abort;
    logic [SEC_W-1:0]          sec_left;

    modport master (
        output req,
        output dur_sec,
        input  grant,
        input  busy,
        input  done,
        input  abort,
        input  sec_left
    );

    modport slave (
        input  req,
        input  dur_sec,
        output grant,
        output busy,
        output done,
        output abort,
        output sec_left
    );
endinterface

// File: rtl/mains_timer_sched.sv
// ---------------------------------------------------------------------------
// mains_timer_sched
//
// Round-robin scheduler sharing one countdown timer between CHANNELS
// requesters. Runs on the mains-frequency clock, prescales it by
// TICKS_PER_SEC to whole seconds, and counts the owner's duration down.
// On expiry the owner's done bit pulses; if the owner drops req first the
// run is aborted with a single abort pulse instead.
//
// Ports:
//   clk_in  mains-frequency clock, all logic on posedge
//   rst     synchronous, active-high reset
//   bus     mains_timer_sched_if.slave (req, dur_sec in; grant, busy,
//           done, abort, sec_left out, all outputs registered)
// ---------------------------------------------------------------------------
module mains_timer_sched #(
    parameter int CHANNELS      = 4,
    parameter int TICKS_PER_SEC = 50,
    parameter int SEC_W         = 10
) (
    input  logic                     clk_in,
    input  logic                     rst,
    mains_timer_sched_if.slave       bus
);

    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW1     = CH_W + 1;
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       owner_q, owner_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [CHANNELS-1:0]   grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [CHANNELS-1:0]   done_q, done_d;
    logic                  abort_q, abort_d;
    logic [SEC_W-1:0]      sec_left_q, sec_left_d;

    // Per-channel duration fields and one-hot codes, unpacked once.
    logic [SEC_W-1:0]      dur_arr [CHANNELS];
    logic [CHANNELS-1:0]   onehot_arr [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign dur_arr[gi]    = bus.dur_sec[gi*SEC_W +: SEC_W];
            assign onehot_arr[gi] = CHANNELS'(1) << gi;
        end
    endgenerate

    // Round-robin pick: first set request searching upward from rr_ptr,
    // wrapping past CHANNELS-1 back to 0. cand is one bit wider so the
    // sum cannot overflow before the wrap correction.
    logic [CH_W-1:0] pick_idx;
    logic            pick_found;
    logic [CW1-1:0]  cand;

    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, rr_ptr_q} + CW1'(i);
            if (cand >= CW1'(CHANNELS)) begin
                cand = cand - CW1'(CHANNELS);
            end
            if (!pick_found && bus.req[cand[CH_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CH_W-1:0];
            end
        end
    end

    logic             owner_req;
    logic [SEC_W-1:0] owner_dur;
    logic [CH_W-1:0]  owner_succ;

    assign owner_req  = bus.req[owner_q];
    assign owner_dur  = dur_arr[owner_q];
    assign owner_succ = (owner_q == LAST_CH) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        presc_d    = presc_q;
        grant_d    = grant_q;
        sec_left_d = sec_left_q;
        done_d     = '0;
        abort_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_LOAD;
                    owner_d = pick_idx;
                    grant_d = onehot_arr[pick_idx];
                end
            end

            S_LOAD: begin
                if (!owner_req) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else begin
                    // Duration is latched here only; later changes are ignored.
                    sec_left_d = owner_dur;
                    presc_d    = '0;
                    if (owner_dur == '0) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // Withdrawal is checked first so it beats a coincident final tick.
                if (!owner_req) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (sec_left_q != '0) begin
                        sec_left_d = sec_left_q - 1'b1;
                    end
                    if (sec_left_q <= SEC_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            S_DONE, S_ABORT: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                rr_ptr_d   = owner_succ;
                sec_left_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            presc_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= '0;
            abort_q    <= 1'b0;
            sec_left_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            presc_q    <= presc_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            sec_left_q <= sec_left_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;
    assign bus.sec_left = sec_left_q;

endmodule

// File: tb/tb_mains_timer_sched.sv
// ---------------------------------------------------------------------------
// tb_mains_timer_sched
//
// Directed bench for mains_timer_sched (CHANNELS=4, TICKS_PER_SEC=50,
// SEC_W=10). Inputs change and outputs are sampled 1 time unit after each
// rising edge. Expected values are hand-computed edge counts.
// ---------------------------------------------------------------------------
module tb_mains_timer_sched;

    localparam int CH  = 4;
    localparam int TPS = 50;
    localparam int SW  = 10;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    mains_timer_sched_if #(.CHANNELS(CH), .SEC_W(SW)) bus ();

    mains_timer_sched #(
        .CHANNELS      (CH),
        .TICKS_PER_SEC (TPS),
        .SEC_W         (SW)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dur(input int d0, input int d1, input int d2, input int d3);
        bus.dur_sec = {SW'(d3), SW'(d2), SW'(d1), SW'(d0)};
    endtask

    initial begin
        bus.req = '0;
        set_dur(0, 0, 0, 0);

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_grant",    32'(bus.grant),    0);
        chk("rst_busy",     32'(bus.busy),     0);
        chk("rst_done",     32'(bus.done),     0);
        chk("rst_abort",    32'(bus.abort),    0);
        chk("rst_sec_left", 32'(bus.sec_left), 0);
        rst = 1'b0;

        // ---------------- single request, dur0=2 ----------------
        set_dur(2, 0, 0, 0);
        bus.req = 4'b0001;
        tick();                                   // E0
        chk("t1_grant",     32'(bus.grant),    4'b0001);
        chk("t1_busy",      32'(bus.busy),     1);
        chk("t1_sec_load",  32'(bus.sec_left), 0);
        tick();                                   // E1
        chk("t1_sec_e1",    32'(bus.sec_left), 2);
        repeat (49) tick();                       // E50
        chk("t1_sec_e50",   32'(bus.sec_left), 2);
        tick();                                   // E51
        chk("t1_sec_e51",   32'(bus.sec_left), 1);
        repeat (49) tick();                       // E100
        chk("t1_sec_e100",  32'(bus.sec_left), 1);
        chk("t1_done_e100", 32'(bus.done),     0);
        tick();                                   // E101
        chk("t1_done_e101", 32'(bus.done),     4'b0001);
        chk("t1_sec_e101",  32'(bus.sec_left), 0);
        chk("t1_grant_e101",32'(bus.grant),    4'b0001);
        tick();                                   // E102
        chk("t1_done_clr",  32'(bus.done),     0);
        chk("t1_grant_clr", 32'(bus.grant),    0);
        chk("t1_busy_clr",  32'(bus.busy),     0);
        bus.req = '0;

        // ---------------- round robin, all dur=1 ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_dur(1, 1, 1, 1);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            tick();
            chk($sformatf("rr%0d_grant", k), 32'(bus.grant), 32'(exp_g));
            repeat (50) tick();
            chk($sformatf("rr%0d_done_early", k), 32'(bus.done), 0);
            tick();
            chk($sformatf("rr%0d_done", k), 32'(bus.done), 32'(exp_g));
            tick();
            chk($sformatf("rr%0d_idle_grant", k), 32'(bus.grant), 0);
        end
        bus.req = '0;                             // rr_ptr now 1

        // ---------------- zero duration on channel 2 ----------------
        set_dur(1, 1, 0, 1);
        bus.req = 4'b0100;
        tick();
        chk("z_grant",    32'(bus.grant),    4'b0100);
        tick();
        chk("z_done",     32'(bus.done),     4'b0100);
        chk("z_sec",      32'(bus.sec_left), 0);
        chk("z_busy",     32'(bus.busy),     1);
        tick();
        chk("z_done_clr", 32'(bus.done),     0);
        chk("z_grant_clr",32'(bus.grant),    0);
        bus.req = '0;                             // rr_ptr now 3

        // ---------------- abort on channel 1 ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_dur(1, 3, 1, 1);
        bus.req = 4'b0010;
        tick();                                   // E0
        chk("ab_grant",   32'(bus.grant),    4'b0010);
        tick();                                   // E1
        chk("ab_sec_e1",  32'(bus.sec_left), 3);
        bus.req = 4'b0111;                        // others wait during the run
        repeat (69) tick();                       // E70
        chk("ab_sec_e70", 32'(bus.sec_left), 2);
        chk("ab_grant_e70", 32'(bus.grant),  4'b0010);
        bus.req = 4'b0101;                        // withdraw channel 1
        tick();                                   // E71
        chk("ab_abort",   32'(bus.abort),    1);
        chk("ab_no_done", 32'(bus.done),     0);
        chk("ab_busy",    32'(bus.busy),     0);
        tick();                                   // E72
        chk("ab_abort_clr", 32'(bus.abort),  0);
        chk("ab_grant_clr", 32'(bus.grant),  0);
        chk("ab_sec_clr",   32'(bus.sec_left), 0);
        tick();                                   // E73: rr_ptr=2 picks 2 before 0
        chk("ab_next_grant", 32'(bus.grant), 4'b0100);
        repeat (51) tick();
        chk("ab_ch2_done", 32'(bus.done),    4'b0100);
        bus.req = 4'b0001;
        tick();
        chk("ab_ch2_clr",  32'(bus.grant),   0);
        tick();                                   // channel 0 served after 2
        chk("ab_ch0_grant", 32'(bus.grant),  4'b0001);

        // ---------------- abort vs final tick, dur0=1 ----------------
        tick();
        chk("fx_sec_load", 32'(bus.sec_left), 1);
        repeat (49) tick();
        chk("fx_sec_pre",  32'(bus.sec_left), 1);
        chk("fx_done_pre", 32'(bus.done),     0);
        bus.req = 4'b0000;                        // drop on the final-tick edge
        tick();
        chk("fx_abort",    32'(bus.abort),    1);
        chk("fx_no_done",  32'(bus.done),     0);
        tick();
        chk("fx_abort_clr",32'(bus.abort),    0);
        chk("fx_done_clr", 32'(bus.done),     0);
        chk("fx_grant_clr",32'(bus.grant),    0);

        // ---------------- reset mid-run ----------------
        set_dur(5, 5, 1, 1);
        bus.req = 4'b0010;                        // rr_ptr=1 after the abort
        tick();
        chk("rm_grant1",   32'(bus.grant),    4'b0010);
        tick();
        bus.req = 4'b0011;
        repeat (10) tick();
        chk("rm_sec_run",  32'(bus.sec_left), 5);
        rst = 1'b1;
        tick();
        chk("rm_grant",    32'(bus.grant),    0);
        chk("rm_busy",     32'(bus.busy),     0);
        chk("rm_done",     32'(bus.done),     0);
        chk("rm_abort",    32'(bus.abort),    0);
        chk("rm_sec",      32'(bus.sec_left), 0);
        rst = 1'b0;
        tick();                                   // rr_ptr back at 0
        chk("rm_restart_grant", 32'(bus.grant), 4'b0001);
        tick();
        chk("rm_restart_sec",   32'(bus.sec_left), 5);
        bus.req = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mains_timer_sched.md
# mains_timer_sched

Round-robin scheduler that shares one mains-derived countdown timer between several requesters (e.g. pump, heater and light controllers). Runs directly on the mains-frequency clock and prescales it to whole seconds internally. Grants the timer to one requester at a time, loads that requester's duration and counts it down in seconds. When the interval expires the block pulses that requester's done line; if the requester withdraws early, it aborts the run instead.

## Interface
- CHANNELS, 4: number of requesters (2..8).
- TICKS_PER_SEC, 50: clk_in cycles per second (mains frequency).
- SEC_W, 10: width of each duration field in seconds.
- clk_in  input  1  mains-frequency clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  CHANNELS  level request per channel; held high until done or abort.
- dur_sec  input  CHANNELS*SEC_W  duration per channel; channel i at bits [i*SEC_W +: SEC_W].
- grant  output  CHANNELS  one-hot; the owner of the timer.
- busy  output  1  high in LOAD, RUN and DONE.
- done  output  CHANNELS  one-cycle pulse on the owner's bit when its interval completes.
- abort  output  1  one-cycle pulse when the owner drops req before completion.
- sec_left  output  SEC_W  remaining whole seconds of the current run; 0 when idle.

## Operation
- States: IDLE, LOAD, RUN, DONE, ABORT. All outputs are registered.
- IDLE → LOAD:
  - Taken on any edge where req ≠ 0.
  - The winner is the first set bit searching upward from rr_ptr, wrapping at CHANNELS-1 to 0.
  - grant is set to the winner's one-hot at the same edge.
- LOAD → RUN:
  - sec_left ← dur_sec of the owner; prescaler presc ← 0.
  - If the loaded dur_sec = 0, LOAD → DONE directly and RUN is skipped.
- RUN, on each edge:
  - If presc = TICKS_PER_SEC-1: presc ← 0 and sec_left ← sec_left-1.
  - If sec_left reaches 0 on that edge, go to DONE.
  - Otherwise presc ← presc+1.
- DONE: done[owner] = 1 for exactly one cycle, then → IDLE.
- ABORT: abort = 1 for exactly one cycle, then → IDLE.
- Leaving DONE or ABORT: grant ← 0 and rr_ptr ← (owner+1) mod CHANNELS.
- Abort: in LOAD or RUN, if req[owner] is sampled 0, go to ABORT next. No done pulse is produced.
- Precedence: if req[owner] is sampled 0 on the same edge as the final second tick, abort wins.
- In DONE or ABORT, req is ignored; no new grant is issued until back in IDLE.
- Requests from non-owners never disturb a run. They wait, with no loss, until the scheduler returns to IDLE.
- dur_sec is sampled only in LOAD; changes during RUN have no effect.
- Arithmetic:
  - presc width is clog2(TICKS_PER_SEC).
  - sec_left never underflows; the decrement happens only while sec_left ≥ 1.
- Reset values:
  - state = IDLE, rr_ptr = 0, presc = 0.
  - grant = 0, busy = 0, done = 0, abort = 0, sec_left = 0.
- rst mid-run drops everything to reset values at that edge, with no done or abort pulse.

## Timing
- Edge E0: req sampled in IDLE → grant and busy visible after E0.
- E1: LOAD → RUN; sec_left = dur visible after E1.
- RUN lasts dur·TICKS_PER_SEC cycles.
  - done asserts after edge E(1+dur·TICKS_PER_SEC).
  - done clears, along with grant and busy, after E(2+dur·TICKS_PER_SEC).
- Zero-length run (dur = 0): done visible after E1, cleared after E2.
- sec_left decrements once every TICKS_PER_SEC cycles, starting TICKS_PER_SEC cycles after LOAD.
- Back-to-back service: IDLE lasts at least one cycle between owners, so the minimum gap from done to the next grant is 1 cycle.
- Abort:
  - req low sampled at edge Ek in RUN → abort visible after Ek.
  - IDLE, with grant = 0, after Ek+1.

## Test plan
- Single request: CHANNELS=4, TICKS_PER_SEC=50, req=0001, dur0=2. Required:
  - grant=0001 one cycle after req.
  - sec_left 2→1→0 at 50-cycle spacing.
  - done=0001 exactly 101 cycles after grant.
  - Single pulse, then grant=0.
- Round robin: req=1111 held, all durations 1. Required:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each done is 51 cycles after its grant.
  - 1 idle cycle between consecutive grants.
- Zero duration: req=0100, dur2=0. Required: done=0100 one cycle after grant; sec_left stays 0; RUN is never entered.
- Abort: dur1=3, drop req[1] 70 cycles into RUN. Required: abort pulse one cycle later; no done; grant=0; rr_ptr=2, so a pending req[0] is served after req[2].
- Abort vs. final tick: dur0=1, drop req[0] on the same edge as the final second tick. Required: abort pulses, done stays 0.
- Reset mid-run: assert rst during RUN with sec_left=5. Required: at the next edge all outputs = 0 and state IDLE; after release with req held, service restarts from channel 0 with the full duration.
